// File: rtl/soc_system_alarm_div_pkg.sv
// Shared register map, bit positions and helpers for the multi-channel alarm divider.
package soc_system_alarm_div_pkg;

    localparam logic [1:0] REG_DIV  = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_CNT  = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int STAT_RUNNING = 0;
    localparam int STAT_DONE    = 1;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/alarm_div_channel.sv
// One alarm channel: divisor/control registers, down-counter, output and sticky DONE.
module alarm_div_channel
    import soc_system_alarm_div_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        div_wr,
    input  logic        ctrl_wr,
    input  logic        stat_wr,
    input  logic [31:0] writedata,
    input  logic [1:0]  reg_sel,
    output logic [31:0] rd_data,
    output logic        out,
    output logic        irq_req
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] divisor;
    logic [DIV_W-1:0] counter;
    logic             en;
    logic             oneshot;
    logic             irq_en;
    logic             done;
    logic             terminal;
    logic             done_set;
    logic             unused_wdata;

    assign terminal     = en && (counter == '0);
    assign done_set     = terminal && oneshot;
    assign irq_req      = done && irq_en;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divisor <= '0;
        end else if (div_wr) begin
            divisor <= writedata[DIV_W-1:0];
        end
    end

    // An EN=0 write beats a same-cycle terminal event; EN=1 only starts an idle channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en      <= 1'b0;
            oneshot <= 1'b0;
            irq_en  <= 1'b0;
            counter <= '0;
            out     <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                oneshot <= writedata[CTRL_ONESHOT];
                irq_en  <= writedata[CTRL_IRQ_EN];
            end
            if (ctrl_wr && !writedata[CTRL_EN]) begin
                en      <= 1'b0;
                counter <= '0;
                out     <= 1'b0;
            end else if (ctrl_wr && !en) begin
                if (divisor != '0) begin
                    en      <= 1'b1;
                    counter <= divisor - ONE;
                    out     <= 1'b0;
                end
            end else if (en) begin
                if (counter != '0) begin
                    counter <= counter - ONE;
                end else begin
                    counter <= divisor - ONE;
                    if (oneshot) begin
                        en  <= 1'b0;
                        out <= 1'b0;
                    end else begin
                        out <= ~out;
                    end
                end
            end
        end
    end

    // Expiry takes priority over a write-1-to-clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else if (done_set) begin
            done <= 1'b1;
        end else if (stat_wr && writedata[STAT_DONE]) begin
            done <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DIV:  rd_data = 32'(divisor);
            REG_CTRL: rd_data = {29'd0, irq_en, oneshot, en};
            REG_STAT: rd_data = {30'd0, done, en};
            REG_CNT:  rd_data = 32'(counter);
            default:  rd_data = '0;
        endcase
    end

endmodule

// File: rtl/soc_system_alarm_div_multi.sv
// Avalon-MM slave wrapping NUM_CH alarm divider channels: decode, read mux and irq.
module soc_system_alarm_div_multi
    import soc_system_alarm_div_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DIV_W  = 32,
    localparam int ADDR_W = clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] out_port,
    output logic              irq
);

    logic              wr;
    logic [4:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic [31:0]       ch_rd [NUM_CH];
    logic [NUM_CH-1:0] irq_req;

    assign wr      = chipselect && !write_n;
    assign ch_sel  = 5'(address >> 2);
    assign reg_sel = address[1:0];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic ch_hit;
        assign ch_hit = wr && (ch_sel == 5'(gi));

        alarm_div_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .div_wr   (ch_hit && (reg_sel == REG_DIV)),
            .ctrl_wr  (ch_hit && (reg_sel == REG_CTRL)),
            .stat_wr  (ch_hit && (reg_sel == REG_STAT)),
            .writedata(writedata),
            .reg_sel  (reg_sel),
            .rd_data  (ch_rd[gi]),
            .out      (out_port[gi]),
            .irq_req  (irq_req[gi])
        );
    end

    // Channel indices beyond NUM_CH match nothing and read back as zero.
    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 5'(i)) begin
                readdata = ch_rd[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |irq_req;
        end
    end

endmodule

// File: tb/tb_soc_system_alarm_div_multi.sv
// Self-checking bench for soc_system_alarm_div_multi using closed-form timing models.
module tb_soc_system_alarm_div_multi;
    import soc_system_alarm_div_pkg::*;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;
    localparam int ADDR_W = $clog2(NUM_CH) + 2;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] out_port;
    logic              irq;

    int checks   = 0;
    int failures = 0;

    soc_system_alarm_div_multi #(
        .NUM_CH(NUM_CH),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ADDR_W-1:0] reg_addr(input int ch, input logic [1:0] r);
        return ADDR_W'(ch * 4 + int'(r));
    endfunction

    // Continuous mode, k edges after the enabling edge: toggles at d, 2d, 3d, ...
    function automatic logic cont_out(input int k, input int d);
        return ((k / d) % 2) == 1;
    endfunction

    function automatic int cont_count(input int k, input int d);
        return d - 1 - (k % d);
    endfunction

    task automatic bus_write(input int ch, input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        address    = reg_addr(ch, r);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input int ch, input logic [1:0] r, output logic [31:0] d);
        address    = reg_addr(ch, r);
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bus_write(ch, REG_CTRL, 32'h0);
            bus_write(ch, REG_STAT, 32'h2);
        end
        step();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bus_write(0, REG_DIV, 32'd2);
        bus_write(0, REG_CTRL, 32'h1);
        bus_write(1, REG_DIV, 32'd1);
        bus_write(1, REG_CTRL, 32'h7);
        repeat (5) step();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_pre_irq got=%b exp=1", irq);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== '0 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs out_port=%b irq=%b exp 0/0", out_port, irq);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int r = 0; r < 4; r++) begin
                bus_read(ch, 2'(r), rd);
                checks++;
                if (rd !== 32'h0) begin
                    failures++;
                    $display("[TB] FAIL reset_reg ch=%0d reg=%0d got=%h exp=0", ch, r, rd);
                end
            end
        end
        repeat (3) step();
        reset_n = 1'b1;
        repeat (3) step();
        checks++;
        if (out_port !== '0 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_outputs out_port=%b irq=%b exp 0/0", out_port, irq);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int r = 0; r < 4; r++) begin
                bus_read(ch, 2'(r), rd);
                checks++;
                if (rd !== 32'h0) begin
                    failures++;
                    $display("[TB] FAIL reset_release_reg ch=%0d reg=%0d got=%h exp=0", ch, r, rd);
                end
            end
        end
    endtask

    task automatic test_continuous();
        logic [31:0] rd;
        int d;
        for (int n = 0; n < 4; n++) begin
            d = (n == 0) ? 3 : int'($urandom_range(9, 1));
            bus_write(0, REG_DIV, 32'(d));
            bus_write(0, REG_CTRL, 32'h1);
            for (int k = 0; k <= 4 * d + 1; k++) begin
                bus_read(0, REG_CNT, rd);
                checks++;
                if (rd !== 32'(cont_count(k, d))) begin
                    failures++;
                    $display("[TB] FAIL cont_count d=%0d k=%0d got=%0d exp=%0d", d, k, rd, cont_count(k, d));
                end
                checks++;
                if (out_port[0] !== cont_out(k, d)) begin
                    failures++;
                    $display("[TB] FAIL cont_out d=%0d k=%0d got=%b exp=%b", d, k, out_port[0], cont_out(k, d));
                end
                // Re-writing EN=1 mid-run must not restart the count.
                if (k == d + 1) bus_write(0, REG_CTRL, 32'h1);
                else step();
            end
            bus_write(0, REG_CTRL, 32'h0);
            bus_read(0, REG_CNT, rd);
            checks++;
            if (rd !== 32'h0 || out_port[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL cont_disable count=%0d out=%b exp 0/0", rd, out_port[0]);
            end
        end
    endtask

    task automatic test_oneshot_irq();
        logic [31:0] rd;
        logic [31:0] exp;
        int d;
        for (int n = 0; n < 2; n++) begin
            d = (n == 0) ? 10 : int'($urandom_range(12, 2));
            bus_write(1, REG_DIV, 32'(d));
            bus_write(1, REG_CTRL, 32'h7);
            for (int k = 0; k <= d + 2; k++) begin
                bus_read(1, REG_STAT, rd);
                exp = {30'd0, (k >= d), (k < d)};
                checks++;
                if (rd !== exp) begin
                    failures++;
                    $display("[TB] FAIL oneshot_status d=%0d k=%0d got=%h exp=%h", d, k, rd, exp);
                end
                checks++;
                if (irq !== (k >= d + 1) || out_port[1] !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL oneshot_irq d=%0d k=%0d irq=%b out=%b exp irq=%b out=0",
                             d, k, irq, out_port[1], (k >= d + 1));
                end
                step();
            end
            bus_read(1, REG_CTRL, rd);
            checks++;
            if (rd !== 32'h6) begin
                failures++;
                $display("[TB] FAIL oneshot_ctrl_after got=%h exp=6", rd);
            end
            bus_write(1, REG_STAT, 32'h2);
            bus_read(1, REG_STAT, rd);
            checks++;
            if (rd !== 32'h0 || irq !== 1'b1) begin
                failures++;
                $display("[TB] FAIL oneshot_w1c status=%h irq=%b exp 0/1", rd, irq);
            end
            step();
            checks++;
            if (irq !== 1'b0) begin
                failures++;
                $display("[TB] FAIL oneshot_irq_clear got=%b exp=0", irq);
            end
            bus_write(1, REG_CTRL, 32'h0);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] rd;
        logic [31:0] v;
        bus_write(2, REG_DIV, 32'h0);
        bus_write(2, REG_CTRL, 32'h7);
        bus_read(2, REG_CTRL, rd);
        checks++;
        if (rd !== 32'h6) begin
            failures++;
            $display("[TB] FAIL div0_ctrl got=%h exp=6", rd);
        end
        bus_read(2, REG_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL div0_status got=%h exp=0", rd);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (out_port[2] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL div0_out k=%0d got=%b exp=0", k, out_port[2]);
            end
        end
        bus_write(2, REG_DIV, 32'h1);
        bus_write(2, REG_CTRL, 32'h1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_port[2] !== cont_out(k, 1)) begin
                failures++;
                $display("[TB] FAIL div1_out k=%0d got=%b exp=%b", k, out_port[2], cont_out(k, 1));
            end
            step();
        end
        bus_write(2, REG_CTRL, 32'h0);
        for (int n = 0; n < 4; n++) begin
            v = (n == 0) ? 32'h1FF : $urandom;
            bus_write(2, REG_DIV, v);
            bus_read(2, REG_DIV, rd);
            checks++;
            if (rd !== (v & 32'hFF)) begin
                failures++;
                $display("[TB] FAIL div_trunc wrote=%h got=%h exp=%h", v, rd, v & 32'hFF);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd;
        int d;
        quiesce();
        d = int'($urandom_range(8, 2));
        bus_write(1, REG_DIV, 32'(d));
        bus_write(1, REG_CTRL, 32'h3);
        repeat (d - 1) @(posedge clk);
        bus_write(1, REG_STAT, 32'h2);
        bus_read(1, REG_STAT, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("[TB] FAIL sim_w1c_vs_set d=%0d got=%h exp=2", d, rd);
        end
        bus_write(1, REG_STAT, 32'h2);
        bus_read(1, REG_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL sim_w1c_later got=%h exp=0", rd);
        end

        d = int'($urandom_range(8, 2));
        bus_write(1, REG_DIV, 32'(d));
        bus_write(1, REG_CTRL, 32'h3);
        repeat (d - 1) @(posedge clk);
        bus_write(1, REG_CTRL, 32'h2);
        bus_read(1, REG_STAT, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("[TB] FAIL sim_disable_oneshot_status d=%0d got=%h exp=2", d, rd);
        end
        bus_read(1, REG_CNT, rd);
        checks++;
        if (rd !== 32'h0 || out_port[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sim_disable_oneshot_cnt count=%0d out=%b exp 0/0", rd, out_port[1]);
        end

        d = int'($urandom_range(6, 2));
        bus_write(0, REG_DIV, 32'(d));
        bus_write(0, REG_CTRL, 32'h1);
        repeat (d - 1) @(posedge clk);
        bus_write(0, REG_CTRL, 32'h0);
        bus_read(0, REG_CNT, rd);
        checks++;
        if (rd !== 32'h0 || out_port[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sim_disable_cont d=%0d count=%0d out=%b exp 0/0", d, rd, out_port[0]);
        end
        quiesce();
    endtask

    task automatic test_divisor_change();
        logic [31:0] rd;
        int d_old;
        int d_new;
        int w;
        int exp_cnt;
        logic exp_out;
        for (int n = 0; n < 3; n++) begin
            if (n == 0) begin
                d_old = 5;
                w     = 2;
                d_new = 2;
            end else begin
                d_old = int'($urandom_range(9, 4));
                w     = int'($urandom_range(d_old - 1, 1));
                d_new = int'($urandom_range(6, 1));
            end
            bus_write(2, REG_DIV, 32'(d_old));
            bus_write(2, REG_CTRL, 32'h1);
            for (int k = 0; k <= d_old + 3 * d_new; k++) begin
                if (k < d_old) begin
                    exp_out = 1'b0;
                    exp_cnt = d_old - 1 - k;
                end else begin
                    exp_out = ((1 + (k - d_old) / d_new) % 2) == 1;
                    exp_cnt = d_new - 1 - ((k - d_old) % d_new);
                end
                bus_read(2, REG_CNT, rd);
                checks++;
                if (rd !== 32'(exp_cnt) || out_port[2] !== exp_out) begin
                    failures++;
                    $display("[TB] FAIL divchg d_old=%0d d_new=%0d k=%0d count=%0d out=%b exp %0d/%b",
                             d_old, d_new, k, rd, out_port[2], exp_cnt, exp_out);
                end
                if (k + 1 == w) bus_write(2, REG_DIV, 32'(d_new));
                else step();
            end
            bus_write(2, REG_CTRL, 32'h0);
        end
    endtask

    task automatic test_unused_channel();
        logic [31:0] rd;
        quiesce();
        bus_write(0, REG_DIV, 32'h5A);
        bus_write(0, REG_CTRL, 32'h6);
        for (int r = 0; r < 4; r++) begin
            bus_read(NUM_CH, 2'(r), rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("[TB] FAIL unused_read reg=%0d got=%h exp=0", r, rd);
            end
        end
        bus_write(NUM_CH, REG_DIV, 32'h33);
        bus_write(NUM_CH, REG_CTRL, 32'h7);
        bus_read(0, REG_DIV, rd);
        checks++;
        if (rd !== 32'h5A) begin
            failures++;
            $display("[TB] FAIL unused_write_div got=%h exp=5a", rd);
        end
        bus_read(0, REG_CTRL, rd);
        checks++;
        if (rd !== 32'h6) begin
            failures++;
            $display("[TB] FAIL unused_write_ctrl got=%h exp=6", rd);
        end
        bus_read(NUM_CH, REG_DIV, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL unused_readback got=%h exp=0", rd);
        end
        repeat (4) step();
        checks++;
        if (out_port !== '0 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL unused_outputs out_port=%b irq=%b exp 0/0", out_port, irq);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        $display("[TB] starting");
        test_reset();
        test_continuous();
        test_oneshot_irq();
        test_boundaries();
        test_simultaneous();
        test_divisor_change();
        test_unused_channel();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_system_alarm_div_multi.md
Name: soc_system_alarm_div_multi

Overview:
Parametrised, multi-channel successor to the single-register Avalon-MM alarm divider PIO.
- Each channel holds a programmable divisor and counts it down internally.
- Each channel drives either a continuous square wave or a one-shot timer completion.
- Sits on the HPS/Qsys lightweight Avalon-MM bridge as slave s1; channel outputs go to alarm/buzzer logic; one level interrupt goes to the HPS.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- DIV_W, 32, divisor/counter width in bits (2..32).
- ADDR_W, clog2(NUM_CH)+2, word-address width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  ADDR_W  word address; [ADDR_W-1:2] = channel, [1:0] = register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  combinational read mux; zero-extended; 0 for unused bits.
- out_port  out  NUM_CH  per-channel alarm output.
- irq  out  1  level interrupt.

Behaviour:
Register map, per channel:
- 0 DIVISOR (RW, DIV_W bits).
- 1 CONTROL (RW): bit0 EN, bit1 ONESHOT, bit2 IRQ_EN.
- 2 STATUS: bit0 RUNNING (RO, = EN), bit1 DONE (sticky, write-1-to-clear).
- 3 COUNT (RO, current counter).
- Channel index >= NUM_CH: reads 0, writes ignored.

Reset (reset_n=0, immediate): all DIVISOR, CONTROL, DONE, counters = 0; out_port = 0; irq = 0.

Write = chipselect & ~write_n. Single-cycle; no wait states; no read latency.

Enable:
- A CONTROL write taking EN 0->1 with DIVISOR != 0 loads counter = DIVISOR-1 and out = 0 on the same edge.
- EN=1 written while DIVISOR == 0: EN bit stays 0; other bits are written.
- Writing EN=1 while already running does not restart the counter.

Running, per cycle:
- counter != 0: counter decrements.
- counter == 0 (terminal event): counter reloads DIVISOR-1 (the current DIVISOR value).
  - ONESHOT=0: out toggles. Period = 2*DIVISOR cycles. DIVISOR=1 gives clk/2.
  - ONESHOT=1: DONE <= 1, EN <= 0, out = 0. Expiry is DIVISOR cycles after the enabling write edge.

Disable: writing EN=0 clears the counter to 0 and out to 0 on the next edge. DONE is unchanged.

DIVISOR write while running: no effect until the next reload. DIVISOR is truncated to DIV_W bits.

Simultaneous events:
- DONE set and W1C in the same cycle: set wins.
- Terminal event in the same cycle as an EN=0 write: the write wins, and DONE is still set if ONESHOT=1.

irq = OR over channels of (DONE & IRQ_EN), registered (one cycle after DONE).

Decomposition:
- Package soc_system_alarm_div_pkg: register offsets (REG_DIV=0, REG_CTRL=1, REG_STAT=2, REG_CNT=3), CONTROL/STATUS bit positions, clog2 function.
- Sub-module alarm_div_channel: one counter/output/DONE per channel, instantiated NUM_CH times via generate.
- Top level holds address decode, read mux and irq OR-reduce.

Test Plan:
- Reset: hold reset_n low mid-run with ch0 toggling -> out_port=0, irq=0, all registers read 0 immediately after reset asserts, and still 0 after release.
- Continuous: ch0 DIVISOR=3, CONTROL=1 -> out_port[0] rises 3 cycles after the write edge; period 6 cycles; COUNT reads 2,1,0,2.
- One-shot with irq: ch1 DIVISOR=10, CONTROL=0x7 -> DONE=1 and EN=0 after 10 cycles; irq=1 one cycle later; write STATUS=0x2 -> DONE=0 and irq=0.
- Boundaries:
  - DIVISOR=0 then CONTROL=1 -> RUNNING=0, out stays 0.
  - DIVISOR=1 -> clk/2 square wave.
  - DIV_W=8 with writedata 0x1FF -> DIVISOR reads 0xFF.
- Simultaneous: W1C DONE in the exact cycle a one-shot expires -> DONE reads 1.
- Mid-run divisor change: ch2 running with DIVISOR=5, write 2 at COUNT=3 -> next half-period still 5 cycles, then 2; address of channel NUM_CH reads 0.
